// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator.
// Divides clk by CLK_DIV into a pixel strobe, then steps horizontal/vertical
// counters and produces registered sync, blanking and line/frame markers,
// all aligned with pixel_x/pixel_y.
// Optional feature: define VTG_FRAME_CNT_EN to add a 16-bit frame_cnt port.
module video_timing_gen #(
    parameter int CLK_DIV = 4,
    parameter int CW      = 10,
    parameter int HD      = 640,
    parameter int HF      = 16,
    parameter int HR      = 96,
    parameter int HB      = 48,
    parameter int VD      = 480,
    parameter int VF      = 10,
    parameter int VR      = 2,
    parameter int VB      = 33,
    parameter int HS_POL  = 0,
    parameter int VS_POL  = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          p_tick,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          h_sync,
    output logic          v_sync,
    output logic          video_on,
    output logic          line_start,
    output logic          frame_start
`ifdef VTG_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    localparam int HT = HD + HF + HR + HB;
    localparam int VT = VD + VF + VR + VB;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(HT - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(VT - 1);

    // Range bounds carry one extra bit so HD+HF+HR == 2^CW cannot overflow
    localparam logic [CW:0] H_DISP = (CW+1)'(HD);
    localparam logic [CW:0] HS_BEG = (CW+1)'(HD + HF);
    localparam logic [CW:0] HS_END = (CW+1)'(HD + HF + HR);
    localparam logic [CW:0] V_DISP = (CW+1)'(VD);
    localparam logic [CW:0] VS_BEG = (CW+1)'(VD + VF);
    localparam logic [CW:0] VS_END = (CW+1)'(VD + VF + VR);

    localparam logic HS_ACT = (HS_POL != 0);
    localparam logic VS_ACT = (VS_POL != 0);

    logic [DW-1:0] div, div_nx;
    logic [CW-1:0] h, v, h_nx, v_nx;
    logic [CW:0]   hx, vx;
    logic          frame_wrap;

    assign p_tick  = enable && (div == DIV_LAST);
    assign pixel_x = h;
    assign pixel_y = v;
    assign hx      = {1'b0, h_nx};
    assign vx      = {1'b0, v_nx};

    // Next-state counters; outputs are decoded from these to stay skew-free
    always_comb begin
        div_nx     = (div == DIV_LAST) ? '0 : div + 1'b1;
        h_nx       = h;
        v_nx       = v;
        frame_wrap = 1'b0;
        if (p_tick) begin
            if (h == H_LAST) begin
                h_nx = '0;
                if (v == V_LAST) begin
                    v_nx       = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_nx = v + 1'b1;
                end
            end else begin
                h_nx = h + 1'b1;
            end
        end
    end

    // Counters and registered timing outputs; reset wins over enable
    always_ff @(posedge clk) begin
        if (reset) begin
            div         <= '0;
            h           <= '0;
            v           <= '0;
            h_sync      <= ~HS_ACT;
            v_sync      <= ~VS_ACT;
            video_on    <= 1'b1;
            line_start  <= 1'b1;
            frame_start <= 1'b1;
        end else if (enable) begin
            div         <= div_nx;
            h           <= h_nx;
            v           <= v_nx;
            h_sync      <= (hx >= HS_BEG && hx < HS_END) ? HS_ACT : ~HS_ACT;
            v_sync      <= (vx >= VS_BEG && vx < VS_END) ? VS_ACT : ~VS_ACT;
            video_on    <= (hx < H_DISP) && (vx < V_DISP);
            line_start  <= (h_nx == '0);
            frame_start <= (h_nx == '0) && (v_nx == '0);
        end
    end

`ifdef VTG_FRAME_CNT_EN
    // Completed-frame counter, bumped on the strobe that wraps the raster
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (frame_wrap) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end
`endif

endmodule
